// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM bus arbiter for init, refresh, write and read sub-controllers
module sdram_arbiter (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [12:0] init_addr,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [12:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [12:0] wr_addr,
  input  logic        wr_sdram_en,
  input  logic [15:0] wr_data,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [12:0] rd_addr,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe
);

  localparam logic [3:0]  CMD_NOP   = 4'b0111;
  localparam logic [1:0]  BA_IDLE   = 2'b11;
  localparam logic [12:0] ADDR_IDLE = 13'h1fff;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_wr;
  logic [3:0]  r_cmd;
  logic [3:0]  w_cmd;
  logic [1:0]  w_ba;
  logic [12:0] w_addr;

  // State register; reset is asynchronous so the bus is released immediately
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: refresh wins, write/read ties alternate, owners leave only on their own end pulse
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INIT: begin
        if (init_end) begin
          w_next_state = S_ARBIT;
        end
      end
      S_ARBIT: begin
        if (aref_req) begin
          w_next_state = S_AREF;
        end else if (wr_req && rd_req) begin
          w_next_state = r_last_wr ? S_READ : S_WRITE;
        end else if (wr_req) begin
          w_next_state = S_WRITE;
        end else if (rd_req) begin
          w_next_state = S_READ;
        end
      end
      S_AREF: begin
        if (aref_end) begin
          w_next_state = S_ARBIT;
        end
      end
      S_WRITE: begin
        if (wr_end) begin
          w_next_state = S_ARBIT;
        end
      end
      S_READ: begin
        if (rd_end) begin
          w_next_state = S_ARBIT;
        end
      end
      default: w_next_state = S_INIT;
    endcase
  end

  // Remember whether the most recent write/read grant went to the writer
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_last_wr <= 1'b0;
    end else if (r_state == S_ARBIT && w_next_state == S_WRITE) begin
      r_last_wr <= 1'b1;
    end else if (r_state == S_ARBIT && w_next_state == S_READ) begin
      r_last_wr <= 1'b0;
    end
  end

  // Grants drop in the same cycle the owner signals completion
  always_comb begin
    aref_en = (r_state == S_AREF)  && !aref_end;
    wr_en   = (r_state == S_WRITE) && !wr_end;
    rd_en   = (r_state == S_READ)  && !rd_end;
  end

  // Bus mux: current owner drives command/bank/address, idle pattern while arbitrating
  always_comb begin
    w_cmd  = CMD_NOP;
    w_ba   = BA_IDLE;
    w_addr = ADDR_IDLE;
    case (r_state)
      S_INIT: begin
        w_cmd  = init_cmd;
        w_ba   = init_ba;
        w_addr = init_addr;
      end
      S_AREF: begin
        w_cmd  = aref_cmd;
        w_ba   = aref_ba;
        w_addr = aref_addr;
      end
      S_WRITE: begin
        w_cmd  = wr_cmd;
        w_ba   = wr_ba;
        w_addr = wr_addr;
      end
      S_READ: begin
        w_cmd  = rd_cmd;
        w_ba   = rd_ba;
        w_addr = rd_addr;
      end
      default: begin
        w_cmd  = CMD_NOP;
        w_ba   = BA_IDLE;
        w_addr = ADDR_IDLE;
      end
    endcase
  end

  // Pin registers; write data is captured only while the writer owns the bus
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cmd        <= CMD_NOP;
      sdram_ba     <= BA_IDLE;
      sdram_addr   <= ADDR_IDLE;
      sdram_dq_out <= 16'h0;
      sdram_dq_oe  <= 1'b0;
    end else begin
      r_cmd       <= w_cmd;
      sdram_ba    <= w_ba;
      sdram_addr  <= w_addr;
      sdram_dq_oe <= (r_state == S_WRITE) && wr_sdram_en;
      if (r_state == S_WRITE) begin
        sdram_dq_out <= wr_data;
      end
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = r_cmd;

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Arbitrates access to the single SDRAM command/address/data bus between the initialization, auto-refresh, write and read sub-controllers. It holds the bus for initialization until `init_end`, then grants the bus to one requester at a time. Priority is refresh first, then write/read with round-robin tie-break. The granted requester's command, bank and address are registered onto the SDRAM pins. The block sits between the sub-controllers and the SDRAM pin interface, at the top of the SDRAM controller.

## Interface
- No parameters. Fixed encodings: `cmd` = {cs_n, ras_n, cas_n, we_n}, NOP = 4'b0111; idle bank = 2'b11; idle address = 13'h1fff.
- `sys_clk`  in  1  system clock; all logic is on the rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `init_end`  in  1  initialization complete.
- `init_cmd`/`init_ba`/`init_addr`  in  4/2/13  initialization module bus.
- `aref_req`, `aref_end`  in  1 each  refresh request (level), refresh done (1-cycle pulse).
- `aref_cmd`/`aref_ba`/`aref_addr`  in  4/2/13  refresh module bus.
- `wr_req`, `wr_end`  in  1 each  write request (level), write done (pulse).
- `wr_cmd`/`wr_ba`/`wr_addr`  in  4/2/13  write module bus.
- `wr_sdram_en`  in  1  write module drives DQ.
- `wr_data`  in  16  write data.
- `rd_req`, `rd_end`  in  1 each  read request (level), read done (pulse).
- `rd_cmd`/`rd_ba`/`rd_addr`  in  4/2/13  read module bus.
- `aref_en`, `wr_en`, `rd_en`  out  1 each  grant to each requester.
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n`  out  1 each  registered command.
- `sdram_ba`  out  2  registered bank.
- `sdram_addr`  out  13  registered address.
- `sdram_dq_out`  out  16  registered write data.
- `sdram_dq_oe`  out  1  registered DQ output enable.

## Operation
- States: INIT, ARBIT, AREF, WRITE, READ. Reset state is INIT.
- INIT → ARBIT on the first cycle `init_end`=1. Requests seen in INIT are ignored. Once ARBIT is reached, `init_end` is not re-examined.
- ARBIT arbitration:
  - `aref_req` → AREF.
  - Otherwise, `wr_req` and `rd_req` both high: grant the one not granted last (`last_wr` flag). Reset value of `last_wr` = 0, so the first tie goes to WRITE.
  - Otherwise, only `wr_req` → WRITE; only `rd_req` → READ.
  - No request → stay in ARBIT.
- `last_wr` is set on entry to WRITE and cleared on entry to READ.
- Exit from AREF/WRITE/READ: go to ARBIT on the owner's `*_end`=1. `*_end` from a non-owner is ignored.
- ARBIT lasts at least 1 cycle between any two grants.
- Grants (combinational):
  - `aref_en` = (state==AREF) && !`aref_end`.
  - `wr_en` = (state==WRITE) && !`wr_end`.
  - `rd_en` = (state==READ) && !`rd_end`.
  - Each grant therefore drops in the same cycle its `*_end` is seen.
- Bus mux, selected by current state:
  - INIT → `init_*`; AREF → `aref_*`; WRITE → `wr_*`; READ → `rd_*`.
  - ARBIT → NOP / 2'b11 / 13'h1fff.
- DQ: `sdram_dq_oe` = (state==WRITE) && `wr_sdram_en`; `sdram_dq_out` = `wr_data`. In all other states `sdram_dq_out` holds its previous value and `sdram_dq_oe`=0.
- A request that arrives while another requester owns the bus stays pending (level input) and is arbitrated at the next ARBIT.

## Timing
- Reset values:
  - state=INIT, `last_wr`=0.
  - `sdram_cs_n`/`ras_n`/`cas_n`/`we_n` = 0/1/1/1 (NOP).
  - `sdram_ba`=2'b11, `sdram_addr`=13'h1fff, `sdram_dq_out`=16'h0, `sdram_dq_oe`=0.
  - All grants 0.
- Reset asserted mid-operation: immediate return to INIT, NOP on the pins. Sub-controllers are reset by the same signal.
- Latency:
  - Mux output → pins: 1 cycle.
  - Request high in ARBIT at edge N → state changes at N, grant high during cycle N+1.
  - Owner's `*_end` at edge M → ARBIT at M+1.
- Refresh preempts nothing. A refresh that arrives during a write or read waits until that operation's `*_end`.

## Test plan
- Release reset, hold `init_end`=0 for 10 cycles with `init_cmd`=4'b0010 → pins show PRECHARGE one cycle after each input. After `init_end`=1 → ARBIT, pins show NOP.
- In ARBIT, raise `aref_req`, `wr_req` and `rd_req` in the same cycle → `aref_en` is granted first. Pulse `aref_end` → one ARBIT cycle, then `wr_en`. Pulse `wr_end` → one ARBIT cycle, then `rd_en`.
- Hold `wr_req` and `rd_req` high continuously and pulse each `*_end` after 5 cycles → grants alternate W, R, W, R.
- Assert `aref_req` during WRITE → `wr_en` stays high and `aref_en`=0 until `wr_end`. After one ARBIT cycle, `aref_en`=1.
- In WRITE with `wr_sdram_en`=1 and `wr_data`=16'hA5A5 → `sdram_dq_oe`=1 and `sdram_dq_out`=16'hA5A5 one cycle later. In READ → `sdram_dq_oe`=0.
- Assert reset in the middle of a READ → pins read NOP / 2'b11 / 13'h1fff immediately, `rd_en`=0, and the state is INIT after release.
